// File: rtl/sdp_seg_capture.sv
// Receive side of the multiplexed 7-seg bus. It samples the active-low seg/anode lines and recovers one hex nibble per digit.
// Build option: define SDP_DP_CAPTURE_EN to add dp_out and to include the decimal point in the stability compare.
module sdp_seg_capture #(
    parameter int unsigned DIGITS        = 8,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            seg_in,
    input  logic [DIGITS-1:0]     an_in,
    output logic [4*DIGITS-1:0]   value,
    output logic [DIGITS-1:0]     digit_ok,
    output logic                  frame_done,
    output logic                  err
`ifdef SDP_DP_CAPTURE_EN
    ,
    output logic [DIGITS-1:0]     dp_out
`endif
);

    typedef enum logic [1:0] {WAIT, COUNT, HELD} state_t;

    state_t                state, state_next;
    logic [7:0]            s_seg;
    logic [DIGITS-1:0]     s_an;
    logic [7:0]            cmp_seg;
    logic [7+DIGITS:0]     sample, ref_pat, ref_next;
    logic [CNT_W-1:0]      cnt, cnt_next;
    logic                  legal, capture, start;
    logic [DIGITS-1:0]     cap_mask, seen, seen_next;
    logic [3:0]            nibble;
    logic                  nib_ok;

`ifdef SDP_DP_CAPTURE_EN
    assign cmp_seg = s_seg;
`else
    logic dp_keep;
    assign dp_keep = 1'b0;
    assign cmp_seg = {s_seg[7] & dp_keep, s_seg[6:0]};
`endif

    assign sample    = {cmp_seg, s_an};
    assign legal     = ($countones(~s_an) == 1);
    assign cap_mask  = ~s_an;
    assign seen_next = seen | (capture ? cap_mask : '0);

    always_comb begin
        nibble = 4'h0;
        nib_ok = 1'b1;
        case (s_seg[6:0])
            7'h40: nibble = 4'h0;
            7'h79: nibble = 4'h1;
            7'h24: nibble = 4'h2;
            7'h30: nibble = 4'h3;
            7'h19: nibble = 4'h4;
            7'h12: nibble = 4'h5;
            7'h02: nibble = 4'h6;
            7'h78: nibble = 4'h7;
            7'h00: nibble = 4'h8;
            7'h10: nibble = 4'h9;
            7'h08: nibble = 4'hA;
            7'h03: nibble = 4'hB;
            7'h46: nibble = 4'hC;
            7'h21: nibble = 4'hD;
            7'h06: nibble = 4'hE;
            7'h0E: nibble = 4'hF;
            default: nib_ok = 1'b0;
        endcase
    end

    // The capture fires on the edge where the counter would reach STABLE_CYCLES-1,
    // so a pattern sampled STABLE_CYCLES times in a row lands on that same edge.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        ref_next   = ref_pat;
        capture    = 1'b0;
        start      = 1'b0;
        case (state)
            WAIT:  start = 1'b1;
            COUNT: begin
                if (sample == ref_pat) begin
                    if (cnt == CNT_W'(STABLE_CYCLES - 2)) begin
                        capture    = 1'b1;
                        state_next = HELD;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end else begin
                    start = 1'b1;
                end
            end
            HELD:  start = (sample != ref_pat);
            default: start = 1'b1;
        endcase
        if (start) begin
            cnt_next = '0;
            ref_next = sample;
            if (!legal) begin
                state_next = WAIT;
            end else if (STABLE_CYCLES == 1) begin
                capture    = 1'b1;
                state_next = HELD;
            end else begin
                state_next = COUNT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= WAIT;
            cnt     <= '0;
            ref_pat <= '0;
            s_seg   <= '0;
            s_an    <= '1;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            ref_pat <= ref_next;
            s_seg   <= seg_in;
            s_an    <= an_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value      <= '0;
            digit_ok   <= '0;
            seen       <= '0;
            frame_done <= 1'b0;
            err        <= 1'b0;
`ifdef SDP_DP_CAPTURE_EN
            dp_out     <= '0;
`endif
        end else begin
            frame_done <= &seen_next;
            seen       <= (&seen_next) ? '0 : seen_next;
            err        <= capture && !nib_ok;
            for (int unsigned i = 0; i < DIGITS; i++) begin
                if (capture && cap_mask[i]) begin
                    if (nib_ok) begin
                        value[4*i +: 4] <= nibble;
                        digit_ok[i]     <= 1'b1;
                    end else begin
                        digit_ok[i]     <= 1'b0;
                    end
`ifdef SDP_DP_CAPTURE_EN
                    dp_out[i] <= ~s_seg[7];
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_sdp_seg_capture.sv
// Bench for sdp_seg_capture: table vectors, hand sequences, and randomized bus traffic checked against a run-length model.
module tb_sdp_seg_capture;

    localparam int unsigned S = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  seg_in;
    logic [7:0]  an_in;
    logic [31:0] value;
    logic [7:0]  digit_ok;
    logic        frame_done;
    logic        err;
`ifdef SDP_DP_CAPTURE_EN
    logic [7:0]  dp_out;
`endif

    sdp_seg_capture #(.DIGITS(8), .STABLE_CYCLES(S), .CNT_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .seg_in     (seg_in),
        .an_in      (an_in),
        .value      (value),
        .digit_ok   (digit_ok),
        .frame_done (frame_done),
        .err        (err)
`ifdef SDP_DP_CAPTURE_EN
        ,
        .dp_out     (dp_out)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int frame_cnt = 0;
    int err_cnt   = 0;

    logic [6:0] codes [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int decode(input logic [6:0] s);
        for (int k = 0; k < 16; k++)
            if (codes[k] == s) return k;
        return -1;
    endfunction

    function automatic int low_idx(input logic [7:0] an);
        int n = 0;
        int idx = -1;
        for (int k = 0; k < 8; k++)
            if (!an[k]) begin n++; idx = k; end
        return (n == 1) ? idx : -1;
    endfunction

    function automatic logic [7:0] mask_dp(input logic [7:0] s);
`ifdef SDP_DP_CAPTURE_EN
        return s;
`else
        return {1'b0, s[6:0]};
`endif
    endfunction

    // Reference model: a digit is captured when the same legal pattern has been
    // seen on exactly S consecutive registered samples.
    initial begin : monitor
        logic [7:0]  prev_seg, prev_an, cur_seg, cur_an;
        logic [15:0] last, pat;
        int unsigned run;
        logic [3:0]  mval [8];
        logic [7:0]  mok, mseen;
        logic        mframe, merr, cur_rst;
        logic [31:0] mflat;
        int d, n;
        prev_seg = '0; prev_an = '1; last = '0; run = 0; mok = '0; mseen = '0;
        for (int k = 0; k < 8; k++) mval[k] = '0;
        forever begin
            @(posedge clk);
            cur_rst = rst; cur_seg = seg_in; cur_an = an_in;
            mframe = 1'b0; merr = 1'b0;
            if (cur_rst) begin
                prev_seg = '0; prev_an = '1; run = 0; mok = '0; mseen = '0;
                for (int k = 0; k < 8; k++) mval[k] = '0;
            end else begin
                pat = {mask_dp(prev_seg), prev_an};
                d = low_idx(prev_an);
                if (d < 0) run = 0;
                else if (run > 0 && pat == last) run = (run < S + 1) ? run + 1 : run;
                else run = 1;
                last = pat;
                if (d >= 0 && run == S) begin
                    n = decode(prev_seg[6:0]);
                    if (n >= 0) begin mval[d] = 4'(n); mok[d] = 1'b1; end
                    else begin mok[d] = 1'b0; merr = 1'b1; end
                    mseen[d] = 1'b1;
                    if (&mseen) begin mframe = 1'b1; mseen = '0; end
                end
                prev_seg = cur_seg; prev_an = cur_an;
            end
            for (int k = 0; k < 8; k++) mflat[4*k +: 4] = mval[k];
            #1;
            check("model_value", value, mflat);
            check("model_digit_ok", {24'h0, digit_ok}, {24'h0, mok});
            check("model_frame_done", {31'h0, frame_done}, {31'h0, mframe});
            check("model_err", {31'h0, err}, {31'h0, merr});
            frame_cnt += int'(frame_done);
            err_cnt   += int'(err);
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        seg_in = 8'($urandom);
        an_in  = 8'($urandom);
        repeat (2) @(negedge clk);
        check("reset_value", value, 32'h0);
        check("reset_digit_ok", {24'h0, digit_ok}, 32'h0);
        check("reset_pulses", {30'h0, frame_done, err}, 32'h0);
        rst = 1'b0;
        an_in = '1;
        seg_in = '1;
        frame_cnt = 0;
        err_cnt = 0;
    endtask

    task automatic hold(input logic [7:0] an, input logic [7:0] seg, input int cycles);
        an_in = an;
        seg_in = seg;
        repeat (cycles) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0]  an;
        logic [7:0]  seg;
        int          cycles;
        logic [31:0] exp_value;
        logic [7:0]  exp_ok;
        int          exp_frames;
        int          exp_errs;
    } vec_t;

    vec_t vecs [13];

    initial begin
        rst = 1'b1;
        seg_in = '1;
        an_in = '1;

        vecs[0]  = '{8'hFE, 8'hC0, 8,  32'h0000_0000, 8'h01, 0, 0};
        vecs[1]  = '{8'hFD, 8'hF9, 8,  32'h0000_0010, 8'h03, 0, 0};
        vecs[2]  = '{8'hFB, 8'hA4, 8,  32'h0000_0210, 8'h07, 0, 0};
        vecs[3]  = '{8'hF7, 8'hB0, 8,  32'h0000_3210, 8'h0F, 0, 0};
        vecs[4]  = '{8'hEF, 8'h99, 8,  32'h0004_3210, 8'h1F, 0, 0};
        vecs[5]  = '{8'hDF, 8'h92, 8,  32'h0054_3210, 8'h3F, 0, 0};
        vecs[6]  = '{8'hBF, 8'h82, 8,  32'h0654_3210, 8'h7F, 0, 0};
        vecs[7]  = '{8'h7F, 8'hF8, 8,  32'h7654_3210, 8'hFF, 1, 0};
        vecs[8]  = '{8'hF7, 8'hFF, 8,  32'h7654_3210, 8'hF7, 1, 1};
        vecs[9]  = '{8'hF7, 8'hB0, 8,  32'h7654_3210, 8'hFF, 1, 1};
        vecs[10] = '{8'hFC, 8'hC0, 20, 32'h7654_3210, 8'hFF, 1, 1};
        vecs[11] = '{8'hFF, 8'hC0, 20, 32'h7654_3210, 8'hFF, 1, 1};
        vecs[12] = '{8'hDF, 8'h88, 8,  32'h76A4_3210, 8'hFF, 1, 1};

        // Latency: capture must appear on the fifth edge after the pins change.
        do_reset();
        hold(8'hFE, 8'hA4, 4);
        check("lat_early_ok", {24'h0, digit_ok}, 32'h0);
        check("lat_early_value", value, 32'h0);
        hold(8'hFE, 8'hA4, 1);
        check("lat_value", {28'h0, value[3:0]}, 32'h2);
        check("lat_ok", {31'h0, digit_ok[0]}, 32'h1);
        hold(8'hFE, 8'hA4, 1);

        // Digit scan, illegal blank, bad anode patterns.
        do_reset();
        for (int i = 0; i < 13; i++) begin
            hold(vecs[i].an, vecs[i].seg, vecs[i].cycles);
            check($sformatf("vec%0d_value", i), value, vecs[i].exp_value);
            check($sformatf("vec%0d_ok", i), {24'h0, digit_ok}, {24'h0, vecs[i].exp_ok});
            check($sformatf("vec%0d_frames", i), frame_cnt, vecs[i].exp_frames);
            check($sformatf("vec%0d_errs", i), err_cnt, vecs[i].exp_errs);
        end

        // Segments toggling every 2 cycles never settle; then a steady hold captures.
        do_reset();
        for (int i = 0; i < 10; i++)
            hold(8'hFD, (i % 2 == 0) ? 8'hA4 : 8'hB0, 2);
        check("toggle_ok", {31'h0, digit_ok[1]}, 32'h0);
        check("toggle_value", value, 32'h0);
        hold(8'hFD, 8'hF9, 7);
        check("steady_value", {28'h0, value[7:4]}, 32'h1);
        check("steady_ok", {31'h0, digit_ok[1]}, 32'h1);

        // Decimal point flicker on a steady digit.
        do_reset();
        for (int i = 0; i < 8; i++)
            hold(8'hFB, (i % 2 == 0) ? 8'h24 : 8'hA4, 1);
`ifdef SDP_DP_CAPTURE_EN
        check("dp_flicker_ok", {31'h0, digit_ok[2]}, 32'h0);
`else
        check("dp_flicker_ok", {31'h0, digit_ok[2]}, 32'h1);
        check("dp_flicker_value", {28'h0, value[11:8]}, 32'h2);
`endif

        // Randomized traffic, checked by the model every cycle.
        do_reset();
        for (int it = 0; it < 600; it++) begin
            logic [7:0] an, seg;
            int len;
            if ($urandom_range(99) < 85) an = ~(8'h01 << $urandom_range(7));
            else an = 8'($urandom);
            if ($urandom_range(99) < 80) seg = {1'($urandom), codes[$urandom_range(15)]};
            else seg = 8'($urandom);
            len = int'($urandom_range(8, 1));
            for (int c = 0; c < len; c++) begin
                an_in = an;
                seg_in = ($urandom_range(9) == 0) ? (seg ^ 8'h80) : seg;
                rst = ($urandom_range(199) == 0);
                @(negedge clk);
            end
            rst = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
